// File: rtl/echo_receiver_if.sv
// echo_receiver_if: trigger/echo inputs and distance result bundle for the echo receiver
interface echo_receiver_if #(
    parameter int DIST_W = 10
);
    logic              trig;
    logic              echo;
    logic [DIST_W-1:0] distance;
    logic              dist_valid;
    logic              timeout;
    logic              busy;

    modport master (
        output trig, echo,
        input  distance, dist_valid, timeout, busy
    );

    modport slave (
        input  trig, echo,
        output distance, dist_valid, timeout, busy
    );
endinterface

// File: rtl/echo_receiver.sv
// echo_receiver: measures the ultrasonic echo pulse width in cm ticks; optional ECHO_DEGLITCH_EN adds an echo stability filter
module echo_receiver #(
    parameter int CM_DIV   = 5882,
    parameter int WAIT_MAX = 3000000,
    parameter int MAX_CM   = 400,
    parameter int DIST_W   = 10,
    parameter int DEGLITCH = 8
) (
    input logic           clk,
    input logic           reset,
    echo_receiver_if.slave bus
);
    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int DIV_W  = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, DONE} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              echo_dly_q, echo_dly_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIST_W-1:0] cm_cnt_q, cm_cnt_d;
    logic [DIST_W-1:0] distance_q, distance_d;
    logic              timeout_q, timeout_d;
    logic              echo_f, rise, fall;
    logic              wait_last, div_wrap, cm_sat;
    logic [DIST_W-1:0] cm_inc;

    // two-flop synchronizer for the asynchronous echo pin, plus the edge-detect delay stage
    always_comb begin
        sync1_d    = bus.echo;
        sync2_d    = sync1_q;
        echo_dly_d = echo_f;
    end

    // synchronizer and edge-detect registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            echo_dly_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            echo_dly_q <= echo_dly_d;
        end
    end

`ifdef ECHO_DEGLITCH_EN
    localparam int STAB_W = $clog2(DEGLITCH + 1);

    logic              echo_f_q, echo_f_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;

    // echo_f follows the synchronized echo only after it has disagreed for DEGLITCH straight cycles
    always_comb begin
        echo_f_d   = echo_f_q;
        stab_cnt_d = '0;
        if (sync2_q != echo_f_q) begin
            if (stab_cnt_q == STAB_W'(DEGLITCH - 1))
                echo_f_d = sync2_q;
            else
                stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    // stability filter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_f_q   <= 1'b0;
            stab_cnt_q <= '0;
        end else begin
            echo_f_q   <= echo_f_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    assign echo_f = echo_f_q;
`else
    assign echo_f = sync2_q;
`endif

    assign rise      = echo_f & ~echo_dly_q;
    assign fall      = ~echo_f & echo_dly_q;
    assign wait_last = wait_cnt_q == WAIT_W'(WAIT_MAX - 1);
    assign div_wrap  = div_cnt_q == DIV_W'(CM_DIV - 1);
    // MEASURE trails echo_f by one cycle, so the fall cycle closes out the last high cycle
    assign cm_inc    = cm_cnt_q + DIST_W'(div_wrap);
    assign cm_sat    = cm_inc == DIST_W'(MAX_CM);

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next-state logic: saturation wins over a simultaneous fall, rise wins over the wait timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = bus.trig ? WAIT_RISE : IDLE;
            WAIT_RISE: state_d = rise ? MEASURE : (wait_last ? DONE : WAIT_RISE);
            MEASURE:   state_d = (cm_sat || fall) ? DONE : MEASURE;
            default:   state_d = IDLE;
        endcase
    end

    // counters run only in their own state and are cleared while idle; result loads on entry to DONE
    always_comb begin
        wait_cnt_d = (state_q == WAIT_RISE && !wait_last) ? wait_cnt_q + 1'b1 :
                     (state_q == IDLE) ? '0 : wait_cnt_q;
        div_cnt_d  = (state_q == MEASURE) ? (div_wrap ? '0 : div_cnt_q + 1'b1) : '0;
        cm_cnt_d   = (state_q == MEASURE && !cm_sat) ? cm_inc :
                     (state_q == MEASURE) ? cm_cnt_q : '0;
        distance_d = distance_q;
        timeout_d  = timeout_q;
        if (state_q == WAIT_RISE && !rise && wait_last) begin
            distance_d = '0;
            timeout_d  = 1'b1;
        end else if (state_q == MEASURE && cm_sat) begin
            distance_d = DIST_W'(MAX_CM);
            timeout_d  = 1'b1;
        end else if (state_q == MEASURE && fall) begin
            distance_d = cm_inc;
            timeout_d  = 1'b0;
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            div_cnt_q  <= '0;
            cm_cnt_q   <= '0;
            distance_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            div_cnt_q  <= div_cnt_d;
            cm_cnt_q   <= cm_cnt_d;
            distance_q <= distance_d;
            timeout_q  <= timeout_d;
        end
    end

    // outputs: strobe during DONE, busy through DONE, result held until the next measurement
    always_comb begin
        bus.dist_valid = state_q == DONE;
        bus.busy       = state_q != IDLE;
        bus.distance   = distance_q;
        bus.timeout    = timeout_q;
    end
endmodule
